// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/aux data-memory arbiter.
// MEM_ARB_ALIGN_CHECK_EN (optional) enables the misalignment check in mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arbState_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_AUX = 1'b1
    } owner_e;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    // Encoding 2'b11 falls through to the word rule.
    function automatic logic isMisaligned(input logic [1:0] width, input logic [1:0] addrLo);
        if (width == WIDTH_BYTE) return 1'b0;
        if (width == WIDTH_HALF) return addrLo[0];
        return addrLo != 2'b00;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear; tracks how long aux has been losing arbitration.
module starve_counter #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] countReg;
    logic [CNT_W-1:0] countNext;

    always_comb begin
        countNext = countReg;
        if (clr) begin
            countNext = '0;
        end else if (inc && countReg != CNT_W'(LIMIT)) begin
            countNext = countReg + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            countReg <= '0;
        end else begin
            countReg <= countNext;
        end
    end

    assign count = countReg;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter (CPU priority, aux anti-starvation), three-cycle access.
// Define MEM_ARB_ALIGN_CHECK_EN to suppress and flag misaligned word/half accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_width,
    output logic        cpu_stall,
    output logic        cpu_valid,
    output logic [31:0] cpu_rdata,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic [1:0]  aux_width,
    output logic        aux_valid,
    output logic [31:0] aux_rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic [1:0]  DataWidth,
    input  logic [31:0] ReadData,
    output logic        fault
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arbState_e        stateReg;
    arbState_e        stateNext;
    owner_e           ownerReg;
    logic             weReg;
    logic [31:0]      addrReg;
    logic [31:0]      wdataReg;
    logic [1:0]       widthReg;
    logic [CNT_W-1:0] starveCount;
    logic             idle;
    logic             anyReq;
    logic             auxWins;
    logic             starveInc;
    logic             starveClr;
    logic             badAlign;
    logic [31:0]      rdataVec [2];

    assign idle    = (stateReg == ST_IDLE);
    assign anyReq  = cpu_req | aux_req;
    assign auxWins = aux_req & (~cpu_req | (starveCount == CNT_W'(STARVE_LIMIT)));

    // Every IDLE cycle either bumps the count (aux lost a contested round) or clears it.
    assign starveInc = idle & cpu_req & aux_req & ~auxWins;
    assign starveClr = idle & ~starveInc;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) uStarve (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (starveInc),
        .clr   (starveClr),
        .count (starveCount)
    );

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign badAlign = isMisaligned(widthReg, addrReg[1:0]);
`else
    assign badAlign = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateReg <= ST_IDLE;
            ownerReg <= OWNER_CPU;
            weReg    <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            widthReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (idle && anyReq) begin
                ownerReg <= auxWins ? OWNER_AUX : OWNER_CPU;
                weReg    <= auxWins ? aux_we    : cpu_we;
                addrReg  <= auxWins ? aux_addr  : cpu_addr;
                wdataReg <= auxWins ? aux_wdata : cpu_wdata;
                widthReg <= auxWins ? aux_width : cpu_width;
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        cpu_valid = 1'b0;
        aux_valid = 1'b0;
        fault     = 1'b0;
        unique case (stateReg)
            ST_IDLE: begin
                if (anyReq) stateNext = ST_ACCESS;
            end
            ST_ACCESS: begin
                stateNext = ST_DONE;
                MemRead   = ~weReg & ~badAlign;
                MemWrite  = weReg & ~badAlign;
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
                cpu_valid = (ownerReg == OWNER_CPU);
                aux_valid = (ownerReg == OWNER_AUX);
                fault     = badAlign;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Per-requester load data; a store leaves the owner's previous load value in place.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : gRdata
        logic [31:0] rdataReg;
        always_ff @(posedge Clk) begin
            if (Rst) begin
                rdataReg <= '0;
            end else if (stateReg == ST_ACCESS && !weReg && ownerReg == owner_e'(gi)) begin
                rdataReg <= badAlign ? 32'd0 : ReadData;
            end
        end
        assign rdataVec[gi] = rdataReg;
    end

    assign cpu_rdata = rdataVec[0];
    assign aux_rdata = rdataVec[1];
    assign cpu_stall = cpu_req & ~cpu_valid;

    assign Address   = addrReg;
    assign WriteData = wdataReg;
    assign DataWidth = widthReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random two-requester traffic.
// Expectations follow MEM_ARB_ALIGN_CHECK_EN when it is defined for the build.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [1:0]  cpu_width = '0;
    logic        aux_req = 1'b0, aux_we = 1'b0;
    logic [31:0] aux_addr = '0, aux_wdata = '0;
    logic [1:0]  aux_width = '0;
    logic        cpu_stall, cpu_valid, aux_valid, MemRead, MemWrite, fault;
    logic [31:0] cpu_rdata, aux_rdata, Address, WriteData, ReadData;
    logic [1:0]  DataWidth;

    logic [31:0] physMem  [64];
    logic [31:0] modelMem [64];

    int testsRun = 0;
    int testsFailed = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .Clk(Clk), .Rst(Rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_width(cpu_width), .cpu_stall(cpu_stall), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_width(aux_width), .aux_valid(aux_valid), .aux_rdata(aux_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
        .DataWidth(DataWidth), .ReadData(ReadData), .fault(fault)
    );

    always #5 Clk = ~Clk;

    // Word-wide memory indexed by Address[7:2]; writes land on the edge closing the access cycle.
    assign ReadData = physMem[Address[7:2]];
    logic        wrPend = 1'b0;
    logic [5:0]  wrIdx;
    logic [31:0] wrData;
    always @(negedge Clk) begin
        wrPend = MemWrite;
        wrIdx  = Address[7:2];
        wrData = WriteData;
    end
    always @(posedge Clk) if (wrPend) physMem[wrIdx] = wrData;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        testsRun++;
        if (act !== expv) begin
            testsFailed++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic bit misaligned(input logic [1:0] w, input logic [31:0] a);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        if (w == 2'd2) return 1'b0;
        if (w == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          isAux;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic [31:0] rdata;
        bit          flt;
        int          tag;
    } exp_t;

    exp_t        expQ[$];
    bit          ownerLog[$];
    int          cyc = 0;
    int          busy = 0;
    int          starve = 0;
    logic [31:0] lastRdata [2];

    always @(posedge Clk) begin
        exp_t e;
        bit   both;
        if (Rst) begin
            expQ.delete();
            busy = 0;
            starve = 0;
            lastRdata[0] = '0;
            lastRdata[1] = '0;
        end else if (busy > 0) begin
            busy--;
        end else if (cpu_req || aux_req) begin
            both    = cpu_req && aux_req;
            e.isAux = aux_req && (!cpu_req || starve == LIMIT);
            if (both && !e.isAux) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else                  starve = 0;
            e.we    = e.isAux ? aux_we    : cpu_we;
            e.addr  = e.isAux ? aux_addr  : cpu_addr;
            e.wdata = e.isAux ? aux_wdata : cpu_wdata;
            e.width = e.isAux ? aux_width : cpu_width;
            e.flt   = misaligned(e.width, e.addr);
            e.tag   = cyc;
            if (e.we) begin
                if (!e.flt) modelMem[e.addr[7:2]] = e.wdata;
                e.rdata = lastRdata[e.isAux];
            end else begin
                e.rdata = e.flt ? 32'd0 : modelMem[e.addr[7:2]];
                lastRdata[e.isAux] = e.rdata;
            end
            expQ.push_back(e);
            busy = 2;
        end else begin
            starve = 0;
        end
        cyc++;
    end

    // ---------------- monitor ----------------
    bit strobeSeen = 1'b0;
    always @(negedge Clk) begin
        exp_t e;
        check("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && !cpu_valid});
        if (MemRead || MemWrite) begin
            if (expQ.size() == 0) begin
                check("unexpected_strobe", {30'd0, MemRead, MemWrite}, 32'd0);
            end else begin
                e = expQ[0];
                check("strobe_write", {31'd0, MemWrite}, {31'd0, e.we});
                check("strobe_read", {31'd0, MemRead}, {31'd0, !e.we});
                check("strobe_suppressed", {31'd0, e.flt}, 32'd0);
                check("Address", Address, e.addr);
                check("DataWidth", {30'd0, DataWidth}, {30'd0, e.width});
                if (e.we) check("WriteData", WriteData, e.wdata);
                check("strobe_cycle", cyc, e.tag + 1);
                strobeSeen = 1'b1;
            end
        end
        if (cpu_valid || aux_valid) begin
            if (expQ.size() == 0) begin
                check("unexpected_valid", {30'd0, cpu_valid, aux_valid}, 32'd0);
            end else begin
                e = expQ.pop_front();
                check("valid_owner", {31'd0, aux_valid}, {31'd0, e.isAux});
                check("dual_valid", {31'd0, cpu_valid && aux_valid}, 32'd0);
                check("valid_cycle", cyc, e.tag + 2);
                check(e.isAux ? "aux_rdata" : "cpu_rdata", e.isAux ? aux_rdata : cpu_rdata, e.rdata);
                check("fault", {31'd0, fault}, {31'd0, e.flt});
                check("strobe_seen", {31'd0, strobeSeen}, {31'd0, !e.flt});
                ownerLog.push_back(e.isAux);
                $display("[TB] txn %s %s addr=%h width=%0d rdata=%h fault=%0b at cycle %0d",
                         e.isAux ? "aux" : "cpu", e.we ? "store" : "load", e.addr, e.width,
                         e.isAux ? aux_rdata : cpu_rdata, fault, cyc);
            end
            strobeSeen = 1'b0;
        end else begin
            check("fault_idle", {31'd0, fault}, 32'd0);
        end
        if (Rst) strobeSeen = 1'b0;
    end

    // ---------------- stimulus ----------------
    task automatic nextEdge();
        @(posedge Clk);
        #1;
    endtask

    task automatic setCpu(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] wd);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d; cpu_width = wd;
    endtask

    task automatic setAux(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] wd);
        aux_req = r; aux_we = w; aux_addr = a; aux_wdata = d; aux_width = wd;
    endtask

    task automatic waitValid(input bit isAux);
        for (int n = 0; n < 60; n++) begin
            @(negedge Clk);
            if (isAux ? aux_valid : cpu_valid) return;
        end
        check(isAux ? "aux_valid_timeout" : "cpu_valid_timeout",
              {31'd0, isAux ? aux_valid : cpu_valid}, 32'd1);
    endtask

    task automatic randomTraffic(input bit isAux, input int nTxn);
        for (int t = 0; t < nTxn; t++) begin
            int          gap;
            logic [1:0]  w;
            logic [31:0] a;
            bit          we;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) nextEdge();
            w  = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 255));
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                a = (w == 2'd1) ? (a & ~32'd1) : (w == 2'd2) ? a : (a & ~32'd3);
            if (isAux) setAux(1'b1, we, a, $urandom, w);
            else       setCpu(1'b1, we, a, $urandom, w);
            waitValid(isAux);
            nextEdge();
            if (isAux) setAux(1'b0, 1'b0, '0, '0, '0);
            else       setCpu(1'b0, 1'b0, '0, '0, '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pat [6];
        pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 64; i++) begin
            physMem[i]  = 32'h5A00_0000 ^ (i * 32'h0001_0203);
            modelMem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
        end
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("rst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
        check("rst_aux_valid", {31'd0, aux_valid}, 32'd0);
        check("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_aux_rdata", aux_rdata, 32'd0);
        check("rst_Address", Address, 32'd0);
        check("rst_WriteData", WriteData, 32'd0);
        nextEdge();

        // CPU load of 0xDEADBEEF from 0x10
        physMem[4]  = 32'hDEAD_BEEF;
        modelMem[4] = 32'hDEAD_BEEF;
        setCpu(1'b1, 1'b0, 32'h10, 32'h0, 2'b00);
        waitValid(1'b0);
        check("load_deadbeef", cpu_rdata, 32'hDEAD_BEEF);
        nextEdge();
        setCpu(1'b0, 1'b0, '0, '0, '0);

        // aux byte store of 0xAB to 0x23
        setAux(1'b1, 1'b1, 32'h23, 32'hAB, 2'b10);
        waitValid(1'b1);
        nextEdge();
        setAux(1'b0, 1'b0, '0, '0, '0);
        check("aux_store_landed", physMem[8], 32'hAB);

        // CPU word load at misaligned 0x102
        setCpu(1'b1, 1'b0, 32'h102, 32'h0, 2'b00);
        waitValid(1'b0);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        check("misaligned_rdata", cpu_rdata, 32'd0);
`else
        check("misaligned_rdata", cpu_rdata, modelMem[0]);
`endif
        nextEdge();
        setCpu(1'b0, 1'b0, '0, '0, '0);

        // both requesters held: four CPU grants, then aux, then CPU again
        ownerLog.delete();
        setCpu(1'b1, 1'b0, 32'h8, 32'h0, 2'b00);
        setAux(1'b1, 1'b0, 32'hC, 32'h0, 2'b00);
        for (int n = 0; n < 80 && ownerLog.size() < 6; n++) @(negedge Clk);
        nextEdge();
        setCpu(1'b0, 1'b0, '0, '0, '0);
        setAux(1'b0, 1'b0, '0, '0, '0);
        check("starve_grants", {31'd0, ownerLog.size() >= 6}, 32'd1);
        if (ownerLog.size() >= 6)
            for (int i = 0; i < 6; i++)
                check($sformatf("starve_order%0d", i), {31'd0, ownerLog[i]}, {31'd0, pat[i]});
        repeat (4) nextEdge();

        // reset while a CPU store is in its access cycle
        setCpu(1'b1, 1'b1, 32'h40, 32'h1234_5678, 2'b00);
        nextEdge();
        Rst = 1'b1;
        setCpu(1'b0, 1'b0, '0, '0, '0);
        nextEdge();
        Rst = 1'b0;
        check("rst_store_landed", physMem[16], 32'h1234_5678);
        check("rst_mid_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        check("rst_mid_valid", {31'd0, cpu_valid}, 32'd0);
        check("rst_mid_Address", Address, 32'd0);
        repeat (3) nextEdge();
        setCpu(1'b1, 1'b1, 32'h40, 32'hCAFE_0001, 2'b00);
        waitValid(1'b0);
        nextEdge();
        setCpu(1'b0, 1'b0, '0, '0, '0);
        check("reissue_store", physMem[16], 32'hCAFE_0001);

        // random contention
        fork
            randomTraffic(1'b0, 30);
            randomTraffic(1'b1, 30);
        join
        repeat (5) nextEdge();
        check("queue_drained", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
